sdram_port_arbiter: RTL
=======================

Name: sdram_port_arbiter

Overview:
- Two-requester arbiter in front of the board SDRAM controller.
- Port 0 is the control/host CPU (SPI/OSD side); port 1 is the guest core. Both share one SDRAM controller port.
- Grants one word transaction at a time, with round-robin priority on ties.
- Registers all downstream fields and enforces a completion timeout, so a hung controller cannot deadlock the host.

Parameters:
- ADDR_W, 25, word address width.
- DATA_W, 16, data width.
- TIMEOUT, 255, maximum WAIT cycles before abort (1..65535).

Ports:
- clk  in  1  system clock, single domain.
- reset  in  1  synchronous, active-high.
- p0_req, p1_req  in  1  request level; held high with fields stable until that port's ack.
- p0_we, p1_we  in  1  1 = write, 0 = read.
- p0_addr, p1_addr  in  ADDR_W  word address.
- p0_wdata, p1_wdata  in  DATA_W  write data.
- p0_bsel, p1_bsel  in  2  byte selects; bit1 = high byte.
- p0_ack, p1_ack  out  1  one-cycle completion pulse.
- p0_rdata, p1_rdata  out  DATA_W  read data; valid when ack is high and held until the port's next ack.
- ctl_req  out  1  request to SDRAM controller.
- ctl_we  out  1  write enable to controller.
- ctl_addr  out  ADDR_W  address to controller.
- ctl_wdata  out  DATA_W  write data to controller.
- ctl_bsel  out  2  byte selects to controller.
- ctl_ack  in  1  controller completion pulse.
- ctl_rdata  in  DATA_W  controller read data; valid with ctl_ack.
- timeout_err  out  1  one-cycle pulse on abort.
- grant  out  1  port currently or last served (0/1).

Behaviour:
- All outputs are registered.
- Reset values:
  - ctl_req, p*_ack, timeout_err, ctl_we = 0.
  - ctl_addr, ctl_wdata, ctl_bsel, p*_rdata = 0.
  - grant = 1, so the first tie goes to port 0.
  - State = IDLE; timeout counter = 0.
- States: IDLE, WAIT, DONE.
- IDLE, cycle N:
  - If only one req is high, select it.
  - If both are high, select the port not equal to grant (round robin).
  - Latch the selected port's we/addr/wdata/bsel into the ctl_* registers and set grant.
  - Set ctl_req=1 and clear the counter; go to WAIT. ctl_req is visible at N+1.
  - If no req is high, stay in IDLE.
- WAIT:
  - ctl_req is held high and ctl_* fields are held constant.
  - Counter increments each cycle.
  - ctl_ack=1 at cycle M: ctl_req=0 at M+1; p<grant>_rdata = ctl_rdata (reads only; writes leave rdata unchanged); p<grant>_ack=1 at M+1; go to DONE.
  - Counter reaches TIMEOUT without ctl_ack: ctl_req=0; p<grant>_rdata = all ones; p<grant>_ack=1; timeout_err=1 (all for one cycle); go to DONE.
  - If ctl_ack and timeout occur in the same cycle, ctl_ack wins and no timeout_err is raised.
- DONE (one cycle, at M+1): ack is high. The requester must deassert or replace req on the clock edge that ends the ack cycle. Go to IDLE, which samples at M+2.
- Minimum request-to-request spacing is 3 cycles plus controller latency. Best case (ctl_ack in the first WAIT cycle): req seen at N, ack at N+2.
- The non-granted port's req is ignored until IDLE. Its ack never pulses spuriously.
- ctl_ack received in IDLE or DONE is ignored. Stray acks are not forwarded.
- Reset mid-transaction:
  - Next cycle: ctl_req=0, no ack is issued, state = IDLE.
  - The downstream controller must also be reset by the same signal.
- The counter is wide enough for TIMEOUT (16 bits) and never wraps: it saturates at TIMEOUT.

Test Plan:
1. Single port-0 read, addr=0x000123: controller acks 5 cycles after ctl_req with rdata 0xBEEF -> ctl_addr=0x000123, ctl_we=0; p0_ack 1 cycle after ctl_ack; p0_rdata=0xBEEF; p1_ack stays 0.
2. Both ports request in the same cycle after reset, 4 back-to-back transactions each -> grant order 0,1,0,1,0,1,0,1; no port served twice in a row while the other waits.
3. Port-1 write, wdata=0x55AA, bsel=2'b10 -> ctl_wdata=0x55AA, ctl_bsel=2'b10, ctl_we=1; p1_rdata keeps its previous value; p1_ack is a single pulse.
4. TIMEOUT=8, controller never acks -> ctl_req is high for exactly 8 cycles; then p0_ack=1, p0_rdata=0xFFFF, timeout_err=1 for one cycle; arbiter then serves the pending port-1 request.
5. ctl_ack arrives on the exact timeout cycle -> normal completion, timeout_err=0, rdata = controller data.
6. reset asserted in WAIT, 2 cycles after ctl_req -> ctl_req=0 next cycle, no p*_ack; after release, a port-0/port-1 tie grants port 0.

Source files
------------

// File: rtl/sdram_port_arbiter.sv
// Two-port round-robin arbiter in front of a single SDRAM controller port.
// One word transaction at a time; every output is registered and a stuck controller is aborted after TIMEOUT cycles.
module sdram_port_arbiter #(
    parameter int ADDR_W  = 25,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    input  logic [1:0]        p0_bsel,
    output logic              p0_ack,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    input  logic [1:0]        p1_bsel,
    output logic              p1_ack,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              ctl_req,
    output logic              ctl_we,
    output logic [ADDR_W-1:0] ctl_addr,
    output logic [DATA_W-1:0] ctl_wdata,
    output logic [1:0]        ctl_bsel,
    input  logic              ctl_ack,
    input  logic [DATA_W-1:0] ctl_rdata,
    output logic              timeout_err,
    output logic              grant
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT);
    localparam logic [15:0] TIMEOUT_M1  = 16'(TIMEOUT - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [15:0]         r_cnt;
    logic [15:0]         w_cnt_nxt;
    logic                w_sel;
    logic                w_expire;
    logic                w_ctl_req;
    logic                w_ctl_we;
    logic [ADDR_W-1:0]   w_ctl_addr;
    logic [DATA_W-1:0]   w_ctl_wdata;
    logic [1:0]          w_ctl_bsel;
    logic                w_grant;
    logic                w_p0_ack;
    logic                w_p1_ack;
    logic [DATA_W-1:0]   w_p0_rdata;
    logic [DATA_W-1:0]   w_p1_rdata;
    logic                w_timeout_err;

    // Port selection: a lone requester wins, a tie goes to the port not served last.
    always_comb begin
        w_sel = 1'b0;
        if (p0_req && p1_req) begin
            w_sel = ~grant;
        end else if (p1_req) begin
            w_sel = 1'b1;
        end else begin
            w_sel = 1'b0;
        end
    end

    // The abort fires on the cycle whose increment would bring the counter to TIMEOUT.
    assign w_expire = (r_cnt >= TIMEOUT_M1);

    // Next-state and next-output logic for the transaction FSM.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_ctl_req     = ctl_req;
        w_ctl_we      = ctl_we;
        w_ctl_addr    = ctl_addr;
        w_ctl_wdata   = ctl_wdata;
        w_ctl_bsel    = ctl_bsel;
        w_grant       = grant;
        w_p0_ack      = 1'b0;
        w_p1_ack      = 1'b0;
        w_p0_rdata    = p0_rdata;
        w_p1_rdata    = p1_rdata;
        w_timeout_err = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (p0_req || p1_req) begin
                    w_state_nxt = S_WAIT;
                    w_cnt_nxt   = 16'd0;
                    w_ctl_req   = 1'b1;
                    w_grant     = w_sel;
                    w_ctl_we    = w_sel ? p1_we    : p0_we;
                    w_ctl_addr  = w_sel ? p1_addr  : p0_addr;
                    w_ctl_wdata = w_sel ? p1_wdata : p0_wdata;
                    w_ctl_bsel  = w_sel ? p1_bsel  : p0_bsel;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_WAIT: begin
                // A controller ack on the expiry cycle still counts as a normal completion.
                if (ctl_ack) begin
                    w_state_nxt = S_DONE;
                    w_ctl_req   = 1'b0;
                    w_p0_ack    = ~grant;
                    w_p1_ack    = grant;
                    if (!ctl_we) begin
                        if (grant) begin
                            w_p1_rdata = ctl_rdata;
                        end else begin
                            w_p0_rdata = ctl_rdata;
                        end
                    end else begin
                        w_p0_rdata = p0_rdata;
                    end
                end else if (w_expire) begin
                    w_state_nxt   = S_DONE;
                    w_ctl_req     = 1'b0;
                    w_p0_ack      = ~grant;
                    w_p1_ack      = grant;
                    w_timeout_err = 1'b1;
                    if (grant) begin
                        w_p1_rdata = {DATA_W{1'b1}};
                    end else begin
                        w_p0_rdata = {DATA_W{1'b1}};
                    end
                end else begin
                    w_cnt_nxt = (r_cnt == TIMEOUT_LIM) ? r_cnt : r_cnt + 16'd1;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_ctl_req   = 1'b0;
            end
        endcase
    end

    // State, counter and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= 16'd0;
            ctl_req     <= 1'b0;
            ctl_we      <= 1'b0;
            ctl_addr    <= {ADDR_W{1'b0}};
            ctl_wdata   <= {DATA_W{1'b0}};
            ctl_bsel    <= 2'b00;
            grant       <= 1'b1;
            p0_ack      <= 1'b0;
            p1_ack      <= 1'b0;
            p0_rdata    <= {DATA_W{1'b0}};
            p1_rdata    <= {DATA_W{1'b0}};
            timeout_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            ctl_req     <= w_ctl_req;
            ctl_we      <= w_ctl_we;
            ctl_addr    <= w_ctl_addr;
            ctl_wdata   <= w_ctl_wdata;
            ctl_bsel    <= w_ctl_bsel;
            grant       <= w_grant;
            p0_ack      <= w_p0_ack;
            p1_ack      <= w_p1_ack;
            p0_rdata    <= w_p0_rdata;
            p1_rdata    <= w_p1_rdata;
            timeout_err <= w_timeout_err;
        end
    end

endmodule
